// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
//
// Multi-cycle 16-bit shift-add multiplier that performs no arithmetic of its
// own. Every addition is issued to the shared Hack ALU, one operation per cycle:
//   ADD : acc   <= acc + mcand   (taken only when the current multiplier bit is 1)
//   DBL : mcand <= mcand + mcand (always taken; the multiplier also shifts right)
// The product is the low WIDTH bits with two's-complement wrap. Because of the
// wrap, the signed and unsigned interpretations of the product agree.
//
// Ports
//   clk       in   system clock; all state changes on the rising edge
//   reset_n   in   asynchronous active-low reset; aborts any operation in flight
//   start     in   request; sampled only in IDLE or DONE
//   a         in   multiplicand, captured when a start is accepted
//   b         in   multiplier, captured when a start is accepted
//   busy      out  high while in LOAD/ADD/DBL (registered)
//   done      out  one-cycle pulse; product is valid in the same cycle (registered)
//   product   out  result; held until the next operation completes (registered)
//   alu_x     out  ALU x operand (decoded from state and registers)
//   alu_y     out  ALU y operand (decoded from state and registers)
//   alu_ctrl  out  ALU control {zx,nx,zy,ny,f,no}
//   alu_out   in   ALU result; combinational, valid in the same cycle
//
// Parameters
//   WIDTH       operand/product width; only 16 is supported
//   EARLY_EXIT  1: finish once the remaining multiplier bits are all zero
//               0: always process all WIDTH multiplier bits
// -----------------------------------------------------------------------------
module alu_mul_sequencer #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_DBL,
        S_DONE
    } state_t;

    // Hack ALU encodings: {zx,nx,zy,ny,f,no}
    localparam logic [5:0] CTRL_ZERO = 6'b101010;  // constant 0
    localparam logic [5:0] CTRL_ADD  = 6'b000010;  // x + y

    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [4:0]       r_bitcnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_product;

    logic [WIDTH-1:0] w_mplr_shr;
    logic             w_dbl_last;

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

    // Multiplier as it will be after the current DBL; when it is all zero no
    // further ADD can occur, so the loop may stop early.
    assign w_mplr_shr = r_mplr >> 1;
    assign w_dbl_last = (r_bitcnt == LAST_BIT) || (EARLY_EXIT && (w_mplr_shr == '0));

    // ALU drive decodes straight from state so the op lands in the same cycle
    // as the state that owns it.
    // NOTE: every output gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        alu_x    = '0;
        alu_y    = '0;
        alu_ctrl = CTRL_ZERO;
        case (r_state)
            S_ADD: begin
                alu_x    = r_acc;
                alu_y    = r_mcand;
                alu_ctrl = CTRL_ADD;
            end
            S_DBL: begin
                alu_x    = r_mcand;
                alu_y    = r_mcand;
                alu_ctrl = CTRL_ADD;
            end
            default: ;
        endcase
    end

    // NOTE: all state, including registered outputs, uses non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_bitcnt  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_busy   <= 1'b1;
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_mplr   <= b;
                        r_bitcnt <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (EARLY_EXIT && (r_mplr == '0)) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= r_acc;
                    end else if (r_mplr[0]) begin
                        r_state <= S_ADD;
                    end else begin
                        r_state <= S_DBL;
                    end
                end

                S_ADD: begin
                    r_acc   <= alu_out;
                    r_state <= S_DBL;
                end

                S_DBL: begin
                    r_mcand  <= alu_out;
                    r_mplr   <= w_mplr_shr;
                    r_bitcnt <= r_bitcnt + 5'd1;
                    if (w_dbl_last) begin
                        // Any ADD for this operation already happened, so acc
                        // holds the final product.
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= r_acc;
                    end else if (r_mplr[1]) begin
                        r_state <= S_ADD;
                    end else begin
                        r_state <= S_DBL;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_sequencer
//
// Directed bench for alu_mul_sequencer. Two instances share clock and reset:
// u_dut_e (EARLY_EXIT=1) and u_dut_f (EARLY_EXIT=0). Each instance is closed
// around its own combinational Hack ALU model. Expected products and latencies
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_mul_sequencer;

    localparam logic [5:0] CTRL_ZERO = 6'b101010;
    localparam logic [5:0] CTRL_ADD  = 6'b000010;

    logic        clk;
    logic        reset_n;
    logic        start_e;
    logic        start_f;
    logic [15:0] a_in;
    logic [15:0] b_in;

    logic        busy_e, done_e, busy_f, done_f;
    logic [15:0] product_e, alu_x_e, alu_y_e, alu_out_e;
    logic [15:0] product_f, alu_x_f, alu_y_f, alu_out_f;
    logic [5:0]  alu_ctrl_e, alu_ctrl_f;

    int n_checks = 0;
    int n_errors = 0;

    // Selected DUT for the observation helpers: 0 = early exit, 1 = full.
    logic        sel;
    logic        m_busy, m_done;
    logic [15:0] m_prod, m_x, m_y;
    logic [5:0]  m_ctrl;

    logic [15:0] ops_x[$];
    logic [15:0] ops_y[$];

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'h0000 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0000 : y;
        yy = c[2] ? ~yy : yy;
        r  = c[1] ? (xx + yy) : (xx & yy);
        r  = c[0] ? ~r : r;
        return r;
    endfunction

    assign alu_out_e = hack_alu(alu_x_e, alu_y_e, alu_ctrl_e);
    assign alu_out_f = hack_alu(alu_x_f, alu_y_f, alu_ctrl_f);

    assign m_busy = sel ? busy_f     : busy_e;
    assign m_done = sel ? done_f     : done_e;
    assign m_prod = sel ? product_f  : product_e;
    assign m_x    = sel ? alu_x_f    : alu_x_e;
    assign m_y    = sel ? alu_y_f    : alu_y_e;
    assign m_ctrl = sel ? alu_ctrl_f : alu_ctrl_e;

    alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_dut_e (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_e),
        .a        (a_in),
        .b        (b_in),
        .busy     (busy_e),
        .done     (done_e),
        .product  (product_e),
        .alu_x    (alu_x_e),
        .alu_y    (alu_y_e),
        .alu_ctrl (alu_ctrl_e),
        .alu_out  (alu_out_e)
    );

    alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut_f (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_f),
        .a        (a_in),
        .b        (b_in),
        .busy     (busy_f),
        .done     (done_f),
        .product  (product_f),
        .alu_x    (alu_x_f),
        .alu_y    (alu_y_f),
        .alu_ctrl (alu_ctrl_f),
        .alu_out  (alu_out_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present a/b with start on the selected DUT, let the next rising edge
    // accept it (cycle T), and return 1 time unit after that edge (cycle T+1).
    task automatic do_start(input logic s, input logic [15:0] av, input logic [15:0] bv);
        sel  = s;
        a_in = av;
        b_in = bv;
        if (s) start_f = 1'b1;
        else   start_e = 1'b1;
        @(posedge clk);
        #1;
        start_e = 1'b0;
        start_f = 1'b0;
        ops_x.delete();
        ops_y.delete();
    endtask

    // Called in cycle T+1. Walks cycles until done (bounded), recording every
    // ALU add issued. Checks latency, busy cycles, product and op count.
    // pulse_busy drives a spurious start with different operands mid-run.
    task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] exp_prod,
                             input bit pulse_busy);
        int n     = 1;
        int nbusy = 0;
        bit ctrl_ok = 1'b1;
        while (!m_done && n < 200) begin
            if (m_busy) nbusy++;
            if (m_ctrl == CTRL_ADD) begin
                ops_x.push_back(m_x);
                ops_y.push_back(m_y);
            end else if (m_ctrl != CTRL_ZERO) begin
                ctrl_ok = 1'b0;
            end
            if (pulse_busy && n == 2) begin
                a_in = 16'd100;
                b_in = 16'd100;
                if (sel) start_f = 1'b1;
                else     start_e = 1'b1;
            end
            if (pulse_busy && n == 3) begin
                start_e = 1'b0;
                start_f = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start_e = 1'b0;
        start_f = 1'b0;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_cycles"}, nbusy, exp_lat - 1);
        check({tag, "_ctrl_legal"}, 32'(ctrl_ok), 32'd1);
        check({tag, "_alu_ops"}, ops_x.size(), exp_lat - 2);
        check({tag, "_busy_at_done"}, 32'(m_busy), 32'd0);
        check({tag, "_ctrl_at_done"}, 32'(m_ctrl), 32'(CTRL_ZERO));
        check({tag, "_product"}, 32'(m_prod), 32'(exp_prod));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_x[5];
        logic [15:0] exp_y[5];
        exp_x = '{16'd0, 16'd3, 16'd6, 16'd3, 16'd12};
        exp_y = '{16'd3, 16'd3, 16'd6, 16'd12, 16'd12};

        reset_n = 1'b0;
        start_e = 1'b0;
        start_f = 1'b0;
        a_in    = '0;
        b_in    = '0;
        sel     = 1'b0;

        // Reset state
        #23;
        check("rst_busy_e",  32'(busy_e),     32'd0);
        check("rst_done_e",  32'(done_e),     32'd0);
        check("rst_prod_e",  32'(product_e),  32'd0);
        check("rst_ctrl_e",  32'(alu_ctrl_e), 32'(CTRL_ZERO));
        check("rst_x_e",     32'(alu_x_e),    32'd0);
        check("rst_busy_f",  32'(busy_f),     32'd0);
        check("rst_prod_f",  32'(product_f),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1) 3*5: ADD,DBL,DBL,ADD,DBL; done at T+7
        do_start(1'b0, 16'd3, 16'd5);
        check("t1_busy_load", 32'(m_busy), 32'd1);
        wait_done("t1", 7, 16'd15, 1'b0);
        for (int i = 0; i < 5 && i < ops_x.size(); i++) begin
            check($sformatf("t1_op%0d_x", i), 32'(ops_x[i]), 32'(exp_x[i]));
            check($sformatf("t1_op%0d_y", i), 32'(ops_y[i]), 32'(exp_y[i]));
        end
        @(posedge clk);
        #1;
        check("t1_done_pulse", 32'(m_done), 32'd0);
        check("t1_prod_held",  32'(m_prod), 32'd15);
        @(negedge clk);

        // 2) b=0 with early exit: done at T+2, no ALU op
        do_start(1'b0, 16'h1234, 16'h0000);
        wait_done("t2", 2, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);

        // 3) 0xFFFF*0xFFFF: 32 ops, wraps to 1
        do_start(1'b0, 16'hFFFF, 16'hFFFF);
        wait_done("t3", 34, 16'h0001, 1'b0);
        repeat (2) @(negedge clk);

        // 4) -1*2 without early exit: 16 DBL + 1 ADD, done at T+19
        do_start(1'b1, 16'hFFFF, 16'd2);
        wait_done("t4_full", 19, 16'hFFFE, 1'b0);
        repeat (2) @(negedge clk);
        do_start(1'b1, 16'd3, 16'd5);
        wait_done("t4_full_3x5", 20, 16'd15, 1'b0);
        repeat (2) @(negedge clk);
        do_start(1'b0, 16'hFFFF, 16'd2);
        wait_done("t4_early", 5, 16'hFFFE, 1'b0);
        repeat (2) @(negedge clk);

        // 5) start while busy ignored; start in DONE accepted back-to-back
        do_start(1'b0, 16'd7, 16'd9);
        wait_done("t5a", 8, 16'd63, 1'b1);
        do_start(1'b0, 16'd5, 16'd6);
        check("t5_b2b_busy", 32'(m_busy), 32'd1);
        check("t5_b2b_done", 32'(m_done), 32'd0);
        wait_done("t5b", 7, 16'd30, 1'b0);
        repeat (2) @(negedge clk);

        // 6) Asynchronous reset in the middle of an ADD
        do_start(1'b0, 16'd3, 16'd5);
        @(posedge clk);
        #1;
        check("t6_in_add", 32'(m_ctrl), 32'(CTRL_ADD));
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(m_busy), 32'd0);
        check("t6_rst_prod", 32'(m_prod), 32'd0);
        check("t6_rst_done", 32'(m_done), 32'd0);
        check("t6_rst_ctrl", 32'(m_ctrl), 32'(CTRL_ZERO));
        repeat (2) @(posedge clk);
        #1;
        check("t6_no_done", 32'(m_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start(1'b0, 16'd3, 16'd5);
        wait_done("t6_restart", 7, 16'd15, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
